uart_rx_frame_decoder: RTL

- Receive end of the team's 11-bit UART frame: 1 start bit (0), 8 data bits LSB first, 1 parity bit, 1 stop bit (1).
- Oversamples the serial line and reassembles the frame.
- Checks parity and stop bit, then presents the byte with a one-cycle valid strobe and error flags.
- Sits between the board Rx pin and the downstream byte consumer (e.g. 7-segment display driver).

---
 rtl/uart_rx_frame_decoder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_decoder.sv
// ============================================================================
// Module      : uart_rx_frame_decoder
// Description : Oversampling receiver for an 11-bit UART frame (start, 8 data
//               LSB first, parity, stop) with parity/framing error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_frame_decoder #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx_D,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR,
    output logic       Rx_BUSY
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           state_q,   state_d;
    logic             rx_s1_q,   rx_s1_d;
    logic             rx_s2_q,   rx_s2_d;
    logic             rx_prev_q, rx_prev_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic             par_q,     par_d;
    logic             stop_q,    stop_d;
    logic             done_q,    done_d;
    logic [7:0]       data_q,    data_d;
    logic             valid_q,   valid_d;
    logic             perror_q,  perror_d;
    logic             ferror_q,  ferror_d;

    always_comb begin
        state_d   = state_q;
        rx_s1_d   = Rx_D;
        rx_s2_d   = rx_s1_q;
        rx_prev_d = rx_s2_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        stop_d    = stop_q;
        done_d    = 1'b0;
        data_d    = data_q;
        valid_d   = 1'b0;
        perror_d  = perror_q;
        ferror_d  = ferror_q;

        // Outputs publish one cycle after the stop sample, independent of the FSM,
        // so a new frame may already be starting in the same cycle.
        if (done_q) begin
            data_d   = shift_q;
            perror_d = ((^shift_q) ^ par_q) != PARITY_ODD;
            ferror_d = ~stop_q;
            valid_d  = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                // rx_prev_q high doubles as the arming condition: a line that
                // has not been seen high since reset or a break cannot start.
                if (rx_prev_q && !rx_s2_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == C_HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = rx_s2_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == C_BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s2_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (cnt_q == C_BIT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s2_q;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                // Leaving mid-stop-bit lets a back-to-back start edge be caught.
                if (cnt_q == C_BIT_LAST) begin
                    cnt_d   = '0;
                    stop_d  = rx_s2_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rx_s1_q   <= 1'b0;
            rx_s2_q   <= 1'b0;
            rx_prev_q <= 1'b0;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            par_q     <= 1'b0;
            stop_q    <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            perror_q  <= 1'b0;
            ferror_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_s1_q   <= rx_s1_d;
            rx_s2_q   <= rx_s2_d;
            rx_prev_q <= rx_prev_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            stop_q    <= stop_d;
            done_q    <= done_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perror_q  <= perror_d;
            ferror_q  <= ferror_d;
        end
    end

    assign Rx_DATA   = data_q;
    assign Rx_VALID  = valid_q;
    assign Rx_PERROR = perror_q;
    assign Rx_FERROR = ferror_q;
    assign Rx_BUSY   = (state_q != S_IDLE);

endmodule

`default_nettype wire
